// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel word in on valid/ready, MSB-first serial bit stream out with word framing.
// Define TX_RESIDUE_EN to track the running mod-5 residue and report it with word_done.
module serial_word_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             word_div5,
    output logic [2:0]       word_residue
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sh;
    logic done, last, hs;
    assign last = state == SHIFT && cnt == '0;
    assign data_ready = state == IDLE || last;
    assign hs = data_valid && data_ready;
    assign bit_valid = state == SHIFT;
    assign bit_out = bit_valid && sh[WIDTH-1];
    assign word_start = bit_valid && cnt == CW'(WIDTH - 1);
    assign word_done = done;
    always_comb state_n = hs ? SHIFT : last ? IDLE : state;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sh   <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (hs) begin
                sh  <= data_in;
                cnt <= CW'(WIDTH - 1);
            end else if (bit_valid) begin
                sh  <= sh << 1;
                cnt <= cnt - CW'(1);
            end
        end
    end
`ifdef TX_RESIDUE_EN
    logic [2:0] r, r_n;
    logic [3:0] t;
    // the MSB cycle restarts the residue from zero, so back-to-back words never mix
    assign t = {(word_start ? 3'd0 : r), 1'b0} + {3'd0, bit_out};
    assign r_n = t >= 4'd5 ? 3'(t - 4'd5) : t[2:0];
    always_ff @(posedge clk) begin
        if (rst) r <= 3'd0;
        else if (bit_valid) r <= r_n;
    end
    assign word_residue = done ? r : 3'd0;
    assign word_div5 = done && r == 3'd0;
`else
    assign word_residue = 3'd0;
    assign word_div5 = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed and random words checked against a queue-based model of the serial stream.
module tb_serial_word_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic data_valid = 1'b0;
    logic data_ready, bit_out, bit_valid, word_start, word_done, word_div5;
    logic [2:0] word_residue;
    int checks = 0;
    int errors = 0;

    serial_word_tx #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .word_start(word_start), .word_done(word_done), .word_div5(word_div5),
        .word_residue(word_residue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic s;
        logic l;
        int   res;
    } ent_t;
    ent_t q[$];
    logic exp_done = 1'b0;
    int exp_res = 0;
    logic accepted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            ent_t e;
            e.b = w[i];
            e.s = (i == 7);
            e.l = (i == 0);
            e.res = int'(w) % 5;
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] er;
        logic ed;
`ifdef TX_RESIDUE_EN
        er = exp_done ? 3'(exp_res) : 3'd0;
        ed = exp_done && exp_res == 0;
`else
        er = 3'd0;
        ed = 1'b0;
`endif
        chk("bit_valid", 32'(bit_valid), 32'(q.size() > 0));
        chk("bit_out", 32'(bit_out), 32'(q.size() > 0 ? q[0].b : 1'b0));
        chk("word_start", 32'(word_start), 32'(q.size() > 0 ? q[0].s : 1'b0));
        chk("data_ready", 32'(data_ready), 32'(q.size() <= 1));
        chk("word_done", 32'(word_done), 32'(exp_done));
        chk("word_residue", 32'(word_residue), 32'(er));
        chk("word_div5", 32'(word_div5), 32'(ed));
    endtask

    // one clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge
    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        logic hs;
        logic dn;
        int rs;
        rst = r;
        data_valid = v;
        data_in = d;
        check_outputs();
        hs = v && !r && q.size() <= 1;
        dn = 1'b0;
        rs = 0;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_done = 1'b0;
        end else begin
            if (q.size() > 0) begin
                dn = q[0].l;
                rs = q[0].res;
                void'(q.pop_front());
            end
            if (hs) push_word(d);
            exp_done = dn;
            exp_res = rs;
        end
        accepted = hs;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        do begin
            cyc(1'b0, 1'b1, w);
            n++;
        end while (!accepted && n < 40);
        chk("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_word_done", 32'(word_done), 32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        idle(3);
        send(8'h0A);
        idle(10);
        send(8'h07);
        idle(10);
        send(8'hFF);
        send(8'h00);
        idle(10);
        send(8'hA5);
        idle(3);
        cyc(1'b1, 1'b0, 8'h00);
        idle(3);
        send(8'h3C);
        idle(10);
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 9));
            else if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 8'($urandom));
        end
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
